// File: rtl/booth_mult16.sv
// ---------------------------------------------------------------------------
// booth_mult16
//   Byte-serial 16x16 signed multiplier built around a radix-2 Booth
//   sequencer. Four operand bytes (A then B) are collected, the product is
//   formed over 16 Booth steps, then streamed out as four bytes.
//
// Parameters
//   MSB_FIRST  1: operand/product bytes travel most-significant first
//              0: least-significant first
//
// Ports
//   CLK        system clock, rising-edge active
//   reset_n    synchronous active-low reset
//   in_valid   in_byte holds an operand byte
//   in_byte    operand byte stream (A hi, A lo, B hi, B lo when MSB_FIRST=1)
//   in_ready   block accepts in_byte this cycle (LOAD only)
//   out_valid  out_byte holds a product byte (EMIT only)
//   out_byte   product byte stream (P[31:24] .. P[7:0] when MSB_FIRST=1)
//   out_ready  consumer accepts out_byte this cycle
//   busy       high while computing or emitting
//   done_cnt   number of products fully emitted, wraps at 256
// ---------------------------------------------------------------------------
module booth_mult16 #(
  parameter int MSB_FIRST = 1
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] done_cnt
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         idx_q, idx_d;      // next operand byte slot
  logic [1:0]         optr_q, optr_d;    // next product byte to emit
  logic [3:0]         step_q, step_d;    // Booth step counter
  logic [31:0]        opnd_q, opnd_d;    // {A, B}
  logic signed [16:0] acc_q, acc_d;      // Booth partial accumulator
  logic [15:0]        mq_q, mq_d;        // multiplier / low product half
  logic               qm1_q, qm1_d;      // Booth q(-1) bit
  logic [31:0]        prod_q, prod_d;
  logic [7:0]         done_q, done_d;

  logic signed [16:0] mcand;
  logic signed [16:0] sum;

  // Byte position inside {A,B} (3 = A hi, 0 = B lo) for an input index.
  // LSB-first order is A lo, A hi, B lo, B hi, i.e. positions 2,3,0,1.
  function automatic logic [1:0] in_pos(input logic [1:0] idx);
    if (MSB_FIRST != 0) in_pos = 2'd3 - idx;
    else                in_pos = idx ^ 2'd2;
  endfunction

  // Byte position inside P (3 = P[31:24]) for an output pointer.
  function automatic logic [1:0] out_pos(input logic [1:0] ptr);
    if (MSB_FIRST != 0) out_pos = 2'd3 - ptr;
    else                out_pos = ptr;
  endfunction

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_LOAD);
  assign done_cnt  = done_q;
  assign out_byte  = (state_q == ST_EMIT) ? prod_q[{out_pos(optr_q), 3'b000} +: 8] : 8'h00;

  // Booth add/subtract of the sign-extended multiplicand A. A 17-bit
  // accumulator cannot overflow: after every shift it stays in 16-bit range.
  always_comb begin
    mcand = $signed({opnd_q[31], opnd_q[31:16]});
    unique case ({mq_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand;
      2'b10:   sum = acc_q - mcand;
      default: sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    optr_d  = optr_q;
    step_d  = step_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    prod_d  = prod_q;
    done_d  = done_q;

    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          opnd_d[{in_pos(idx_q), 3'b000} +: 8] = in_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Seed the Booth registers on the accepting edge so that all
            // 16 CALC edges are real Booth steps.
            state_d = ST_CALC;
            step_d  = 4'd0;
            acc_d   = '0;
            mq_d    = opnd_d[15:0];
            qm1_d   = 1'b0;
          end
        end
      end

      ST_CALC: begin
        // Arithmetic right shift of {acc, mq, q(-1)} after the add.
        acc_d  = sum >>> 1;
        mq_d   = {sum[0], mq_q[15:1]};
        qm1_d  = mq_q[0];
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          // Shifted {acc[15:0], mq} equals {sum, mq[15:1]}.
          prod_d  = {sum, mq_q[15:1]};
          state_d = ST_EMIT;
          optr_d  = 2'd0;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          optr_d = optr_q + 2'd1;
          if (optr_q == 2'd3) begin
            state_d = ST_LOAD;
            idx_d   = 2'd0;
            done_d  = done_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        idx_d   = 2'd0;
        optr_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      idx_q   <= 2'd0;
      optr_q  <= 2'd0;
      step_q  <= 4'd0;
      opnd_q  <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      prod_q  <= '0;
      done_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      optr_q  <= optr_d;
      step_q  <= step_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_booth_mult16.sv
// ---------------------------------------------------------------------------
// tb_booth_mult16
//   Self-checking bench for booth_mult16 (MSB_FIRST=1): directed vector
//   table, stall/hold/reset sequences and random products compared against
//   plain signed multiplication.
// ---------------------------------------------------------------------------
module tb_booth_mult16;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       busy;
  logic [7:0] done_cnt;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;

  booth_mult16 #(.MSB_FIRST(1)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_ready (out_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          mode;   // 0 always ready, 1 ready pattern 1,0,0,1
    int          gaps;   // idle cycles before each operand byte
    bit          hold;   // keep in_valid high through CALC/EMIT
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic signed [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] p, input int k);
    logic [31:0] s;
    s = p >> (8 * (3 - k));
    return s[7:0];
  endfunction

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int gaps, input bit hold_after);
    logic [31:0] w;
    w = {a, b};
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_byte  = 8'h5A;
        tick;
      end
      in_valid = 1'b1;
      in_byte  = w[8*(3-k) +: 8];
      chk("in_ready_load", in_ready, 1);
      tick;
    end
    if (hold_after) begin
      in_valid = 1'b1;
      in_byte  = 8'hAA;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_latency(input bit hold);
    int e;
    e = 0;
    chk("busy_calc", busy, 1);
    while (!out_valid && e < 40) begin
      if (hold) chk("in_ready_calc", in_ready, 0);
      tick;
      e++;
    end
    chk("latency_edges", e, 16);
  endtask

  task automatic collect(input logic [31:0] p, input int mode, input bit hold);
    logic [7:0] held;
    bit stalled;
    int got;
    int cyc;
    stalled = 0;
    got = 0;
    cyc = 0;
    held = 8'h00;
    while (got < 4 && cyc < 64) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      chk("emit_valid", out_valid, 1);
      chk("busy_emit", busy, 1);
      if (hold) chk("in_ready_emit", in_ready, 0);
      if (stalled) chk("hold_stable", out_byte, held);
      if (out_ready) begin
        chk($sformatf("byte%0d", got), out_byte, exp_byte(p, got));
        got++;
        stalled = 0;
      end else begin
        held = out_byte;
        stalled = 1;
      end
      tick;
      cyc++;
    end
    if (got < 4) chk("emit_timeout", got, 4);
    out_ready = 1'b0;
    exp_done = (exp_done + 1) % 256;
    chk("done_cnt", done_cnt, exp_done);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                        input int mode, input int gaps, input bit hold);
    send_op(a, b, gaps, hold);
    wait_latency(hold);
    collect(p, mode, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic [15:0] ra, rb;
    bit saw_valid;

    tbl[0] = '{16'h1234, 16'h0002, 32'h0000_2468, 0, 0, 0};
    tbl[1] = '{16'h8000, 16'h8000, 32'h4000_0000, 0, 0, 0};
    tbl[2] = '{16'h8000, 16'h0001, 32'hFFFF_8000, 0, 0, 0};
    tbl[3] = '{16'hFFFF, 16'h7FFF, 32'hFFFF_8001, 1, 0, 0};
    tbl[4] = '{16'h1234, 16'h0000, 32'h0000_0000, 0, 2, 0};
    tbl[5] = '{16'h7FFF, 16'h8000, 32'hC000_8000, 0, 0, 1};
    tbl[6] = '{16'h0003, 16'hFFFD, 32'hFFFF_FFF7, 0, 1, 0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", done_cnt, 8'h00);
    reset_n = 1'b1;

    // Directed table: first vector starts on the first edge out of reset.
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].mode, tbl[i].gaps, tbl[i].hold);
    in_valid = 1'b0;

    // Reset pulse in the middle of CALC discards the operation.
    send_op(16'h1111, 16'h2222, 0, 0);
    for (int i = 0; i < 7; i++) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    exp_done = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_done_cnt", done_cnt, 8'h00);
    saw_valid = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) saw_valid = 1;
      tick;
    end
    out_ready = 1'b0;
    chk("midrst_no_output", saw_valid, 0);
    chk("midrst_done_after", done_cnt, 8'h00);
    run_op(16'h0003, 16'hFFFD, 32'hFFFF_FFF7, 0, 0, 0);

    // Random products from a clean reset; 256 products wrap done_cnt.
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    exp_done = 0;
    for (int i = 0; i < 256; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    chk("done_cnt_wrap", done_cnt, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
